// File: rtl/branch_ctrl.sv
// Fetch-stage PC sequencer and conditional jump resolver with flag-stall and flush.
// Optional saturating taken/not-taken counters are built when BRANCH_STATS_EN is defined.
module branch_ctrl #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned PC_INC       = 1,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [ADDR_W-1:0] o_fetch_pc,
  output logic              o_fetch_valid,
  input  logic              i_fetch_ready,
  input  logic              i_jmp_valid,
  input  logic [3:0]        i_jmp_cond,
  input  logic [ADDR_W-1:0] i_jmp_target,
  output logic              o_jmp_ready,
  input  logic [3:0]        i_cpsr,
  input  logic              i_flags_pending,
  output logic              o_redirect,
  output logic              o_flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_taken_cnt,
  output logic [CNT_W-1:0]  o_ntaken_cnt
`endif
);

  localparam logic [3:0] COND_JMP = 4'h0;
  localparam logic [3:0] COND_JEQ = 4'h1;
  localparam logic [3:0] COND_JNE = 4'h2;
  localparam logic [3:0] COND_JGE = 4'h3;
  localparam logic [3:0] COND_JLT = 4'h4;
  localparam logic [3:0] COND_JGT = 4'h5;
  localparam logic [3:0] COND_JLE = 4'h6;

  localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {StRun, StWaitFlags, StFlush} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [FC_W-1:0]   r_flush_cnt;
  logic              r_redirect;
  logic              r_flush;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0]  r_taken_cnt;
  logic [CNT_W-1:0]  r_ntaken_cnt;
`endif

  logic w_n, w_z, w_v, w_cond_true, w_jmp_ready, w_fetch_valid, w_taken;
  logic w_unused_c;

  assign w_n        = i_cpsr[3];
  assign w_z        = i_cpsr[2];
  assign w_v        = i_cpsr[0];
  assign w_unused_c = i_cpsr[1];

  always_comb begin
    w_cond_true = 1'b0;
    case (i_jmp_cond)
      COND_JMP: w_cond_true = 1'b1;
      COND_JEQ: w_cond_true = w_z;
      COND_JNE: w_cond_true = !w_z;
      COND_JGE: w_cond_true = (w_n == w_v);
      COND_JLT: w_cond_true = (w_n != w_v);
      COND_JGT: w_cond_true = !w_z && (w_n == w_v);
      COND_JLE: w_cond_true = w_z || (w_n != w_v);
      default:  w_cond_true = 1'b0;
    endcase
  end

  assign w_jmp_ready   = (r_state == StRun || r_state == StWaitFlags) && i_jmp_valid &&
                         !i_flags_pending;
  assign w_taken       = w_jmp_ready && w_cond_true;
  assign w_fetch_valid = (r_state == StRun) && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StRun;
      r_fetch_pc  <= ADDR_W'(RESET_PC);
      r_flush_cnt <= '0;
      r_redirect  <= 1'b0;
      r_flush     <= 1'b0;
`ifdef BRANCH_STATS_EN
      r_taken_cnt  <= '0;
      r_ntaken_cnt <= '0;
`endif
    end else begin
      r_redirect <= 1'b0;
      r_flush    <= 1'b0;
      if (w_taken) begin
        // Redirect wins over a fetch accepted in the same cycle; flush kills that fetch.
        r_fetch_pc  <= i_jmp_target;
        r_redirect  <= 1'b1;
        r_flush     <= 1'b1;
        r_flush_cnt <= FC_W'(FLUSH_CYCLES);
        r_state     <= StFlush;
      end else begin
        case (r_state)
          StRun: begin
            if (w_fetch_valid && i_fetch_ready) begin
              r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_INC);
            end
            if (i_jmp_valid && i_flags_pending) begin
              r_state <= StWaitFlags;
            end
          end
          StWaitFlags: begin
            // Leave on a not-taken resolve, or if decode drops the jump.
            if (w_jmp_ready || !i_jmp_valid) begin
              r_state <= StRun;
            end
          end
          StFlush: begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
            if (r_flush_cnt <= FC_W'(1)) begin
              r_state <= StRun;
            end
          end
          default: r_state <= StRun;
        endcase
      end
`ifdef BRANCH_STATS_EN
      if (w_jmp_ready && w_cond_true && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
      if (w_jmp_ready && !w_cond_true && (r_ntaken_cnt != '1)) begin
        r_ntaken_cnt <= r_ntaken_cnt + 1'b1;
      end
`endif
    end
  end

  assign o_fetch_pc    = r_fetch_pc;
  assign o_fetch_valid = w_fetch_valid;
  assign o_jmp_ready   = w_jmp_ready;
  assign o_redirect    = r_redirect;
  assign o_flush       = r_flush;
`ifdef BRANCH_STATS_EN
  assign o_taken_cnt   = r_taken_cnt;
  assign o_ntaken_cnt  = r_ntaken_cnt;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: abstract flow model checked every cycle plus
// hand-computed directed expectations. Honours BRANCH_STATS_EN (counters built with CNT_W=2).
module tb_branch_ctrl;

  localparam int FLUSH = 2;
  localparam int CNT_MAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic        jmp_valid = 1'b0;
  logic [3:0]  jmp_cond = 4'h0;
  logic [15:0] jmp_target = 16'h0;
  logic        jmp_ready;
  logic [3:0]  cpsr = 4'h0;
  logic        flags_pending = 1'b0;
  logic        redirect;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [1:0]  taken_cnt;
  logic [1:0]  ntaken_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

`ifdef BRANCH_STATS_EN
  branch_ctrl #(.CNT_W(2)) dut (
`else
  branch_ctrl dut (
`endif
    .i_clk          (clk),
    .i_reset        (reset),
    .o_fetch_pc     (fetch_pc),
    .o_fetch_valid  (fetch_valid),
    .i_fetch_ready  (fetch_ready),
    .i_jmp_valid    (jmp_valid),
    .i_jmp_cond     (jmp_cond),
    .i_jmp_target   (jmp_target),
    .o_jmp_ready    (jmp_ready),
    .i_cpsr         (cpsr),
    .i_flags_pending(flags_pending),
    .o_redirect     (redirect),
    .o_flush        (flush)
`ifdef BRANCH_STATS_EN
    ,
    .o_taken_cnt    (taken_cnt),
    .o_ntaken_cnt   (ntaken_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Jump condition rules on {n,z,c,v}.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, v;
    n = f[3]; z = f[2]; v = f[0];
    case (c)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return n == v;
      4'h4: return n != v;
      4'h5: return !z && (n == v);
      4'h6: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Model: pc, whether waiting on flags, remaining blank cycles after a redirect.
  int m_pc = 0;
  bit m_wait = 1'b0;
  int m_blank = 0;
  bit m_pulse = 1'b0;
  int m_taken = 0;
  int m_ntaken = 0;

  function automatic bit exp_fv();
    return !reset && !m_wait && (m_blank == 0);
  endfunction

  function automatic bit exp_ready();
    return (m_blank == 0) && jmp_valid && !flags_pending;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_wait = 0; m_blank = 0; m_pulse = 0; m_taken = 0; m_ntaken = 0;
    end else begin
      bit fv, rdy, tk;
      fv  = exp_fv();
      rdy = exp_ready();
      tk  = rdy && cond_ok(jmp_cond, cpsr);
      m_pulse = 0;
      if (rdy) begin
        if (tk) m_taken = (m_taken < CNT_MAX) ? m_taken + 1 : m_taken;
        else    m_ntaken = (m_ntaken < CNT_MAX) ? m_ntaken + 1 : m_ntaken;
      end
      if (m_blank > 0) begin
        m_blank--;
      end else if (tk) begin
        m_pc = int'(jmp_target); m_pulse = 1; m_blank = FLUSH; m_wait = 0;
      end else begin
        if (fv && fetch_ready) m_pc = (m_pc + 1) % 65536;
        if (rdy || !jmp_valid) m_wait = 0;
        else if (flags_pending) m_wait = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fetch_valid", fetch_valid, exp_fv());
      check("fetch_pc", fetch_pc, m_pc);
      check("redirect", redirect, m_pulse);
      check("flush", flush, m_pulse);
      if (!reset) check("jmp_ready", jmp_ready, exp_ready());
`ifdef BRANCH_STATS_EN
      check("taken_cnt", taken_cnt, m_taken);
      check("ntaken_cnt", ntaken_cnt, m_ntaken);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [3:0] c, input logic [15:0] t, input logic [3:0] f);
    jmp_valid = 1'b1; jmp_cond = c; jmp_target = t; cpsr = f;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("lit_reset_fv", fetch_valid, 0);
    tick();
    reset = 1'b0;
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_seq_pc", fetch_pc, i);
      check("lit_seq_redirect", redirect, 0);
      tick();
    end

    // Taken JEQ
    jump(4'h1, 16'h0040, 4'b0100);
    @(negedge clk); check("lit_jeq_ready", jmp_ready, 1);
    tick(); jmp_valid = 1'b0;
    @(negedge clk); check("lit_jeq_redirect", redirect, 1); check("lit_jeq_flush", flush, 1);
    check("lit_jeq_fv0", fetch_valid, 0);
    tick();
    @(negedge clk); check("lit_jeq_fv1", fetch_valid, 0);
    tick();
    @(negedge clk); check("lit_jeq_pc", fetch_pc, 16'h0040); check("lit_jeq_fv2", fetch_valid, 1);

    // Not-taken JGT
    tick();
    jump(4'h5, 16'h0999, 4'b1000);
    @(negedge clk); check("lit_jgt_ready", jmp_ready, 1);
    tick(); jmp_valid = 1'b0;
    @(negedge clk); check("lit_jgt_flush", flush, 0); check("lit_jgt_pc", fetch_pc, 16'h0042);

    // Flag stall on JNE, release taken
    tick();
    jump(4'h2, 16'h1234, 4'b0100);
    flags_pending = 1'b1;
    @(negedge clk); check("lit_stall_ready0", jmp_ready, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk); check("lit_stall_fv", fetch_valid, 0); check("lit_stall_ready", jmp_ready, 0);
    end
    tick();
    flags_pending = 1'b0; cpsr = 4'b0000;
    @(negedge clk); check("lit_release_ready", jmp_ready, 1); check("lit_release_fv", fetch_valid, 0);
    tick(); jmp_valid = 1'b0;
    @(negedge clk); check("lit_release_redirect", redirect, 1);
    check("lit_release_pc", fetch_pc, 16'h1234);
    tick(); tick();

    // PC wrap and undefined condition
    jump(4'h0, 16'hFFFF, 4'h0);
    tick(); jmp_valid = 1'b0;
    tick(); tick();
    @(negedge clk); check("lit_wrap_ffff", fetch_pc, 16'hFFFF);
    tick();
    @(negedge clk); check("lit_wrap_0000", fetch_pc, 16'h0000);
    tick();
    jump(4'hF, 16'h0700, 4'hF);
    @(negedge clk); check("lit_undef_ready", jmp_ready, 1);
    tick(); jmp_valid = 1'b0;
    @(negedge clk); check("lit_undef_flush", flush, 0); check("lit_undef_pc", fetch_pc, 16'h0002);

    // Reset while FLUSH count is 1
    tick();
    jump(4'h0, 16'h0080, 4'h0);
    tick(); jmp_valid = 1'b0;
    tick(); reset = 1'b1;
    tick();
    @(negedge clk); check("lit_rst_pc", fetch_pc, 0); check("lit_rst_flush", flush, 0);
    check("lit_rst_fv", fetch_valid, 0);
    reset = 1'b0;
    @(negedge clk); check("lit_rst_fv1", fetch_valid, 1);

    // Five taken jumps
    for (int k = 0; k < 5; k++) begin
      tick(); jump(4'h0, 16'(k * 16), 4'h0);
      tick(); jmp_valid = 1'b0;
      tick(); tick();
    end
    @(negedge clk);
    check("lit_five_pc", fetch_pc, 16'h0040);
`ifdef BRANCH_STATS_EN
    check("lit_taken_sat", taken_cnt, 3);
    check("lit_ntaken_zero", ntaken_cnt, 0);
`endif

    // Mixed pattern checked by the model
    for (int i = 0; i < 48; i++) begin
      tick();
      fetch_ready   = (i % 3) != 0;
      jmp_valid     = (i % 5) == 2;
      jmp_cond      = 4'(i % 8);
      cpsr          = 4'((i * 7) % 16);
      jmp_target    = 16'(i * 16'h0111);
      flags_pending = (i % 11) == 4;
    end
    tick();
    jmp_valid = 1'b0; flags_pending = 1'b0;
    tick(); tick();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
